jtframe_sdram_mux: RTL

//  Parametrised N-slot SDRAM read arbiter with a one-word cache per slot.

---
 rtl/jtframe_sdram_mux.sv | 122 ++++++++++++
 1 files changed

// File: rtl/jtframe_sdram_mux.sv
// N-slot SDRAM read arbiter. Each slot keeps one cached word so a client that
// re-reads the same word gets its data without touching the SDRAM port.
module jtframe_sdram_mux #(
    parameter int                  SLOTS   = 4,
    parameter int                  AW      = 17,
    parameter logic [SLOTS-1:0]    DW16    = {SLOTS{1'b0}},
    parameter logic [SLOTS*22-1:0] OFFSETS = {SLOTS*22{1'b0}},
    parameter int                  RROBIN  = 0
) (
    input  logic                  rst,
    input  logic                  clk,
    input  logic [SLOTS-1:0]      slot_cs,
    input  logic [SLOTS*AW-1:0]   slot_addr,
    output logic [SLOTS-1:0]      slot_ok,
    output logic [SLOTS*16-1:0]   slot_dout,
    input  logic                  downloading,
    output logic                  sdram_req,
    output logic [21:0]           sdram_addr,
    input  logic                  sdram_ack,
    input  logic                  data_dst,
    input  logic                  data_rdy,
    input  logic [15:0]           data_read,
    output logic [1:0]            fsm_state
);
    localparam int SW = $clog2(SLOTS);

    // Handshake: sdram_req rises with sdram_addr and both hold until the cycle
    // sdram_ack is seen; read data is then taken on the first data_rdy.
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    state_t            state;
    logic [15:0]       data_q [SLOTS];
    logic [21:0]       tag_q  [SLOTS];
    logic [SLOTS-1:0]  valid_q;
    logic [21:0]       waddr  [SLOTS];
    logic [SLOTS-1:0]  pending;
    logic [SW-1:0]     grant;
    logic [SW-1:0]     idx;
    logic [SW-1:0]     rr_q;
    logic [SW-1:0]     sel_q;
    logic              unused_ok;

    assign unused_ok = &{1'b0, data_dst};
    assign fsm_state = state;

    // 8-bit slots address bytes: the word is addr>>1 and addr[0] picks the byte.
    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            waddr[i] = OFFSETS[22*i+:22] + (DW16[i] ? 22'(slot_addr[AW*i+:AW])
                                                    : 22'(slot_addr[AW*i+1+:AW-1]));
            slot_ok[i] = slot_cs[i] & valid_q[i] & (tag_q[i] == waddr[i]);
            if (DW16[i])
                slot_dout[16*i+:16] = data_q[i];
            else
                slot_dout[16*i+:16] = {8'h00, slot_addr[AW*i] ? data_q[i][15:8] : data_q[i][7:0]};
        end
    end

    assign pending = slot_cs & ~slot_ok & {SLOTS{~downloading}};

    // Loops run from the far end so the nearest pending candidate is written last.
    always_comb begin
        grant = '0;
        idx   = '0;
        if (RROBIN == 0) begin
            for (int i = SLOTS - 1; i >= 0; i--)
                if (pending[i]) grant = SW'(i);
        end else begin
            for (int k = SLOTS; k >= 1; k--) begin
                idx = SW'((int'(rr_q) + k) % SLOTS);
                if (pending[idx]) grant = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            valid_q    <= '0;
            rr_q       <= SW'(SLOTS - 1);
            sel_q      <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            if (downloading) valid_q <= '0;
            case (state)
                IDLE: begin
                    if (|pending) begin
                        sel_q      <= grant;
                        rr_q       <= grant;
                        sdram_addr <= waddr[grant];
                        sdram_req  <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        state     <= WAIT;
                    end else if (downloading) begin
                        sdram_req <= 1'b0;
                        state     <= IDLE;
                    end
                end
                WAIT: begin
                    // sdram_addr still holds the fetched word address and serves as the tag
                    if (data_rdy) begin
                        data_q[sel_q] <= data_read;
                        tag_q[sel_q]  <= sdram_addr;
                        if (!downloading) valid_q[sel_q] <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
